// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory for the MEM stage: byte/half/word access,
// load extension, misalignment flagging, and a req/ready handshake with LATENCY cycles.
module data_memory_ctrl #(
   parameter int DEPTH   = 32,
   parameter int LATENCY = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic        busy_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               we_q, we_d;
   logic [1:0]         size_q, size_d;
   logic               uns_q, uns_d;
   logic [IDX_W+1:0]   addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               mis_q, mis_d;
   logic               enter_resp;

   logic               acc_we;
   logic [1:0]         acc_size;
   logic               acc_uns;
   logic [IDX_W+1:0]   acc_addr;
   logic [31:0]        acc_wdata;
   logic               acc_mis;
   logic [3:0]         acc_be;
   logic [31:0]        acc_wsh;
   logic [31:0]        mem_word;
   logic               unused_addr;

   logic [31:0] mem_q [DEPTH];

   assign unused_addr = ^addr_i[31:IDX_W+2];

   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (size)
         2'b00:   load_extract = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'b01:   load_extract = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: load_extract = word;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      size_d     = size_q;
      uns_d      = uns_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_i) begin
               we_d    = we_i;
               size_d  = size_i;
               uns_d   = unsigned_i;
               addr_d  = addr_i[IDX_W+1:0];
               wdata_d = wdata_i;
               if (LATENCY == 1) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(LATENCY - 2);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // With LATENCY = 1 the access completes on the accepting edge, so use the live inputs in IDLE.
   always_comb begin
      acc_we    = (state_q == IDLE) ? we_i                 : we_q;
      acc_size  = (state_q == IDLE) ? size_i               : size_q;
      acc_uns   = (state_q == IDLE) ? unsigned_i           : uns_q;
      acc_addr  = (state_q == IDLE) ? addr_i[IDX_W+1:0]    : addr_q;
      acc_wdata = (state_q == IDLE) ? wdata_i              : wdata_q;
      acc_mis   = (acc_size == 2'b11) ||
                  ((acc_size == 2'b01) && acc_addr[0]) ||
                  ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00));
      case (acc_size)
         2'b00:   acc_be = 4'b0001 << acc_addr[1:0];
         2'b01:   acc_be = 4'b0011 << acc_addr[1:0];
         default: acc_be = 4'b1111;
      endcase
      acc_wsh  = acc_wdata << {acc_addr[1:0], 3'b000};
      mem_word = mem_q[acc_addr[IDX_W+1:2]];
      rdata_d  = '0;
      mis_d    = 1'b0;
      if (enter_resp) begin
         mis_d = acc_mis;
         if (!acc_mis && !acc_we)
            rdata_d = load_extract(mem_word, acc_size, acc_addr[1:0], acc_uns);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
      end
   end

   // Array is not reset; a reset held across the commit edge drops the store.
   always_ff @(posedge clk_i) begin
      if (enter_resp && acc_we && !acc_mis && !rst_i) begin
         for (int i = 0; i < 4; i++)
            if (acc_be[i]) mem_q[acc_addr[IDX_W+1:2]][8*i +: 8] <= acc_wsh[8*i +: 8];
      end
   end

   assign ready_o    = (state_q == RESP);
   assign busy_o     = (state_q != IDLE);
   assign rdata_o    = rdata_q;
   assign misalign_o = mis_q;

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised, byte-addressable data memory for the pipeline's MEM stage. It replaces the fixed 32-word, word-only, combinational data memory. The block adds byte, halfword and word accesses, sign and zero extension on loads, and misalignment detection. Accesses use a request/ready handshake with a configurable number of wait cycles, so later cache and stall work can drive it unchanged.

## Interface
- DEPTH, 32: number of 32-bit words; power of two, ≥ 4.
- LATENCY, 1: cycles from request acceptance to ready_o; ≥ 1.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- req_i  input  1  access request; sampled only in IDLE.
- we_i  input  1  1 = store, 0 = load.
- size_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
- unsigned_i  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr_i  input  32  byte address.
- wdata_i  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
- ready_o  output  1  one-cycle completion pulse.
- busy_o  output  1  high whenever state ≠ IDLE.
- rdata_o  output  32  load result; valid only while ready_o = 1, otherwise 0.
- misalign_o  output  1  high with ready_o when the access was illegal or misaligned.

## Operation
- States: IDLE, WAIT, RESP.
- Request capture:
  - In IDLE with req_i = 1, the block latches we, size, unsigned, addr and wdata.
  - LATENCY = 1: next state is RESP.
  - LATENCY > 1: next state is WAIT, with cnt = LATENCY − 2.
- WAIT: decrement cnt each cycle; go to RESP on the cycle cnt = 0. cnt width is clog2(LATENCY) bits, minimum 1.
- RESP: ready_o = 1 for exactly one cycle, then return to IDLE. Requests are not accepted in RESP.
- req_i while busy_o = 1 is ignored. The requester waits for busy_o = 0 and re-presents the request.
- Word index = addr[clog2(DEPTH)+1:2]. Upper address bits are discarded, so addresses wrap modulo 4·DEPTH bytes.
- Little-endian byte lanes:
  - Byte: lane addr[1:0].
  - Half: lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
- Store: on the edge entering RESP, only the enabled lanes of the indexed word are written; the other lanes are preserved.
- Load: on the edge entering RESP, the selected lanes are extracted, shifted to bit 0 and extended per unsigned_i. Word loads ignore unsigned_i.
- Misaligned or illegal access is any of: size 11; half with addr[0] = 1; word with addr[1:0] ≠ 00. For these:
  - No array write.
  - rdata_o = 0.
  - misalign_o = 1 in the RESP cycle.
  - ready_o still pulses.
- Memory contents are not reset; they are X until written.

## Timing
- Reset values: state IDLE, cnt 0, ready_o 0, busy_o 0, rdata_o 0, misalign_o 0.
- Request accepted in cycle T (IDLE, req_i = 1):
  - busy_o = 1 during T+1 … T+LATENCY.
  - ready_o, rdata_o and misalign_o are valid in cycle T+LATENCY.
  - busy_o = 0 in T+LATENCY+1, and a new request may be accepted in that cycle.
- Maximum throughput: one access per LATENCY+1 cycles.
- Outputs are registered; rdata_o and misalign_o return to 0 in the cycle after RESP.
- Store data becomes visible to a load accepted at T+LATENCY+1 or later.
- rst_i asserted in any state: all outputs go to their reset values immediately, without waiting for a clock edge.
  - A pending store not yet in RESP is dropped and the array is unchanged.
  - A store already committed stays committed.
- rst_i deasserted: the first request can be accepted on the first rising edge with rst_i = 0.

## Test plan
- Word round trip, LATENCY = 1:
  - SW 0xDEADBEEF to 0x08 → ready_o at T+1, misalign_o = 0, rdata_o = 0.
  - LW 0x08 → rdata_o = 0xDEADBEEF at T+1.
- Lanes and extension:
  - SW 0x11223344 to 0x08, then SB 0x80 to 0x09 → LW 0x08 = 0x11228044.
  - LB 0x09 = 0xFFFFFF80; LBU 0x09 = 0x00000080.
  - LH 0x0A = 0x00001122.
  - SH 0xBEEF to 0x0A → LW 0x08 = 0xBEEF8044.
- Misalignment:
  - SW 0x12345678 to 0x06 → ready_o with misalign_o = 1; LW 0x04 is unchanged.
  - LH 0x03 → rdata_o = 0, misalign_o = 1.
  - size 11 → misalign_o = 1.
- Handshake, LATENCY = 3:
  - LW accepted at T → busy_o high during T+1..T+3, ready_o only at T+3.
  - req_i held high at T+1..T+3 → no extra accept.
  - Next accept at T+4.
- Wrap, DEPTH = 32: SW 0xA5A5A5A5 to 0x80 → LW 0x00 = 0xA5A5A5A5.
- Reset mid-operation, LATENCY = 3:
  - SW 0xCAFEF00D to 0x10 over prior 0x0 data, with rst_i pulsed at T+2 → outputs 0 during reset.
  - After release, LW 0x10 = 0x00000000.
